// File: rtl/mips_mem_responder_if.sv
// Byte-wide memory bus between the MIPS core and its memory responder,
// plus the TX FIFO drain handshake and the access-statistics outputs.
// master = core/consumer side, slave = responder side.
interface mips_mem_responder_if #(
  parameter int WIDTH = 8
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic [15:0]      rd_count;
  logic [15:0]      wr_count;

  modport master (
    output memread, memwrite, adr, writedata, out_ready,
    input  memdata, out_valid, out_data, rd_count, wr_count
  );

  modport slave (
    input  memread, memwrite, adr, writedata, out_ready,
    output memdata, out_valid, out_data, rd_count, wr_count
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified instruction/data RAM with a TX-data/STATUS I/O window at the top of the address space.
// Latency: reads are combinational from adr; TX pushes appear on out_valid/out_data one cycle after the write edge.
// Backpressure: out_ready stalls the TX FIFO; pushes into a full FIFO with no pop are dropped and set sticky overflow.
// Optional MEMRESP_STATS_EN macro adds 16-bit wrapping read/write access counters (otherwise tied to 0).
module mips_mem_responder #(
  parameter int    WIDTH    = 8,
  parameter int    FIFO_AW  = 2,
  parameter string INITFILE = ""
) (
  input logic                   clk,
  input logic                   reset,
  mips_mem_responder_if.slave   bus
);

  localparam int               RAM_DEPTH  = 2**WIDTH - 2;
  localparam int               FIFO_DEPTH = 2**FIFO_AW;
  localparam logic [WIDTH-1:0] TXDATA_ADR = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STATUS_ADR = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] ram [0:RAM_DEPTH-1];
  logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];

  logic [FIFO_AW:0] wptr, rptr, wptr_n, rptr_n;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             overflow;

  logic             is_ram, is_tx, is_status;
  logic             fifo_empty, fifo_full;
  logic             push, pop, push_ok, ovf_set, ovf_clr;
  logic [7:0]       wbyte, head_n;

  assign is_tx     = (bus.adr == TXDATA_ADR);
  assign is_status = (bus.adr == STATUS_ADR);
  assign is_ram    = !is_tx && !is_status;
  assign wbyte     = bus.writedata[7:0];

  // Full/empty from the extra pointer MSB: same low bits, MSBs differ means wrapped once.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

  // A pop frees a slot in the same edge, so a push into a full FIFO only drops when nothing drains.
  assign push    = bus.memwrite && is_tx;
  assign pop     = out_valid_q && bus.out_ready;
  assign push_ok = reset && push && (!fifo_full || pop);
  assign ovf_set = push && fifo_full && !pop;
  assign ovf_clr = bus.memread && is_status;

  assign wptr_n = push_ok ? wptr + 1'b1 : wptr;
  assign rptr_n = pop     ? rptr + 1'b1 : rptr;

  // Next head byte: the slot being written this edge only becomes the head when it is the sole entry.
  assign head_n = (push_ok && (wptr[FIFO_AW-1:0] == rptr_n[FIFO_AW-1:0])) ?
                  wbyte : fifo_mem[rptr_n[FIFO_AW-1:0]];

  // Zero-latency read mux; driven regardless of memread.
  always_comb begin
    bus.memdata = '0;
    if (is_status)
      bus.memdata = {{(WIDTH-3){1'b0}}, overflow, fifo_full, fifo_empty};
    else if (is_ram)
      bus.memdata = ram[bus.adr];
  end

  // RAM store; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.memwrite && is_ram)
      ram[bus.adr] <= bus.writedata;
  end

  // FIFO storage write; push_ok already excludes reset cycles and dropped pushes.
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wptr[FIFO_AW-1:0]] <= wbyte;
  end

  // FIFO pointers, registered head outputs and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow    <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      out_valid_q <= (wptr_n != rptr_n);
      out_data_q  <= head_n;
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef MEMRESP_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  // Access counters, free-running and wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (bus.memread)
        rd_cnt <= rd_cnt + 16'd1;
      if (bus.memwrite)
        wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt;
  assign bus.wr_count = wr_cnt;
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif

endmodule
